vend_change: RTL and testbench
==============================

Name: vend_change

Overview:
- Parametrised successor to the single-product newspaper vending FSM.
- Accepts three coin denominations and accumulates credit against a configurable PRICE.
- Dispenses one item when credit reaches PRICE, then pays change one CHANGE_UNIT coin per cycle.
- Supports cancel/refund, rejects coins while busy, and keeps a running vend count for the front-panel/monitor logic.

Parameters:
- PRICE, 15: item price in currency units.
- VAL1, 5: value of coin code 2'b01.
- VAL2, 10: value of coin code 2'b10.
- VAL3, 25: value of coin code 2'b11.
- CHANGE_UNIT, 5: value of one dispensed change coin. PRICE and VAL1..VAL3 must be multiples of it; checked at elaboration.
- CREDIT_W, 7: credit register width. Must hold PRICE-CHANGE_UNIT+max(VALn); checked at elaboration.
- COUNT_W, 16: vend counter width.

Ports:
- clock  in  1  system clock; all state changes on posedge.
- reset  in  1  synchronous, active-high reset.
- coin  in  2  coin code, one coin per cycle when nonzero. 00 none, 01 VAL1, 10 VAL2, 11 VAL3.
- cancel  in  1  refund request, sampled each cycle.
- newspaper  out  1  item dispense pulse, high for exactly one cycle per vend.
- change_out  out  1  high for one cycle per CHANGE_UNIT coin returned.
- coin_reject  out  1  registered pulse: the coin sampled on the previous edge was returned, not credited.
- busy  out  1  high in VEND or CHANGE state.
- credit  out  CREDIT_W  current credit.
- vend_count  out  COUNT_W  total vends since reset; wraps modulo 2^COUNT_W.

Behaviour:
- Reset (sync, active-high, overrides all inputs): state ACCUM, credit=0, vend_count=0, coin_reject=0. Hence newspaper=0, change_out=0, busy=0.
- Reset mid-VEND or mid-CHANGE abandons the operation: no further pulses after the reset edge, and undelivered change is lost.
- States: ACCUM, VEND, CHANGE. newspaper, change_out and busy are Moore decodes of the state register: newspaper = (state==VEND), change_out = (state==CHANGE), busy = (state!=ACCUM).

ACCUM:
- cancel=1, credit>0: go to CHANGE (refund); a coin in the same cycle is rejected (coin_reject=1 next cycle). cancel has priority.
- cancel=1, credit=0: no-op; a coin in the same cycle is rejected.
- Otherwise, coin!=00: credit <= credit+val.
  - If credit+val >= PRICE: go to VEND.
  - Else stay in ACCUM.
- coin=00: hold.

VEND:
- Lasts one cycle: credit <= credit-PRICE, vend_count <= vend_count+1.
- Next state is CHANGE if the remainder is >0, else ACCUM.

CHANGE:
- Each cycle: credit <= credit-CHANGE_UNIT.
- Return to ACCUM on the cycle credit reaches 0.
- Number of change_out pulses = remainder/CHANGE_UNIT.

Coin and cancel handling while busy:
- Any nonzero coin in VEND or CHANGE: not credited; coin_reject pulses the following cycle.
- cancel in VEND or CHANGE: ignored.

Latency:
- Coin completing the price sampled at edge n: newspaper high in cycle n+1.
- First change_out in cycle n+2.
- Back in ACCUM (ready) the cycle after the last change pulse.

Arithmetic:
- Unsigned, CREDIT_W bits, no wrap by construction: max credit is PRICE-CHANGE_UNIT+max(VALn).

Decomposition:
- Package vend_pkg:
  - state enum (ACCUM, VEND, CHANGE);
  - coin code constants (COIN_NONE=2'b00, COIN_A=2'b01, COIN_B=2'b10, COIN_C=2'b11).
- Sub-module vend_coin_value: combinational coin code -> CREDIT_W-bit value, parametrised by VAL1..VAL3; returns 0 for COIN_NONE.
- Top holds the FSM, credit register, vend counter and coin_reject register.

Test Plan (defaults: PRICE=15, CHANGE_UNIT=5):
1. Reset, then coin 01,01,01 on three non-consecutive cycles -> credit 5,10,15; newspaper one cycle after the third coin; no change_out; credit=0; vend_count=1.
2. coin 10 then 10 -> credit 20; newspaper 1 cycle; then exactly 1 change_out pulse; credit=0; busy low after 2 cycles.
3. Single coin 11 (25) -> newspaper, then 2 consecutive change_out pulses; credit 10->5->0; vend_count increments by 1.
4. coin 01 then cancel=1 -> no newspaper; 1 change_out pulse; credit=0. cancel with credit=0 -> no output activity.
5. coin 10 on the cycle newspaper is high, and coin 01 during a change pulse -> coin_reject high one cycle after each; credit trajectory unaffected; ACCUM resumes with credit 0. Coin+cancel together in ACCUM with credit 5 -> refund of 1 pulse, coin_reject=1.
6. coin 11, then reset asserted during the first change_out cycle -> next cycle credit=0, change_out=0, busy=0, vend_count=0. Then coin 10,01 -> normal vend.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared definitions for the vend_change vending controller.
//   state_t   : controller states (ACCUM, VEND, CHANGE)
//   COIN_*    : two-bit coin codes presented on the coin input
package vend_pkg;

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    VEND   = 2'd1,
    CHANGE = 2'd2
  } state_t;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_A    = 2'b01;
  localparam logic [1:0] COIN_B    = 2'b10;
  localparam logic [1:0] COIN_C    = 2'b11;

endpackage

// File: rtl/vend_coin_value.sv
// Combinational coin decoder: maps a coin code to its credit value.
//   coin  in  2         coin code (COIN_NONE decodes to 0)
//   value out CREDIT_W  value of the coin in currency units
module vend_coin_value
  import vend_pkg::*;
#(
  parameter int CREDIT_W = 7,
  parameter int VAL1     = 5,
  parameter int VAL2     = 10,
  parameter int VAL3     = 25
) (
  input  logic [1:0]          coin,
  output logic [CREDIT_W-1:0] value
);

  always_comb begin
    value = '0;
    case (coin)
      COIN_A:  value = CREDIT_W'(VAL1);
      COIN_B:  value = CREDIT_W'(VAL2);
      COIN_C:  value = CREDIT_W'(VAL3);
      default: value = '0;
    endcase
  end

endmodule

// File: rtl/vend_change.sv
// Single-product vending controller with change return.
// Accumulates coin credit until PRICE is reached, pulses newspaper for one
// cycle, then returns the remainder one CHANGE_UNIT coin per cycle. cancel
// refunds the accumulated credit the same way. Coins offered while busy, or
// together with cancel, are returned and flagged on coin_reject.
//   clock       in   system clock
//   reset       in   synchronous active-high reset
//   coin        in   coin code (00 none, 01 VAL1, 10 VAL2, 11 VAL3)
//   cancel      in   refund request
//   newspaper   out  one-cycle dispense pulse
//   change_out  out  one pulse per returned change coin
//   coin_reject out  previous-cycle coin was returned
//   busy        out  vend or change in progress
//   credit      out  current credit
//   vend_count  out  vends since reset (wraps)
module vend_change
  import vend_pkg::*;
#(
  parameter int PRICE       = 15,
  parameter int VAL1        = 5,
  parameter int VAL2        = 10,
  parameter int VAL3        = 25,
  parameter int CHANGE_UNIT = 5,
  parameter int CREDIT_W    = 7,
  parameter int COUNT_W     = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [1:0]          coin,
  input  logic                cancel,
  output logic                newspaper,
  output logic                change_out,
  output logic                coin_reject,
  output logic                busy,
  output logic [CREDIT_W-1:0] credit,
  output logic [COUNT_W-1:0]  vend_count
);

  localparam int MAX_VAL = (VAL1 > VAL2) ? ((VAL1 > VAL3) ? VAL1 : VAL3)
                                         : ((VAL2 > VAL3) ? VAL2 : VAL3);
  // Largest credit ever held: one unit short of the price plus the biggest coin.
  localparam int MAX_CREDIT = PRICE - CHANGE_UNIT + MAX_VAL;

  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] UNIT_C  = CREDIT_W'(CHANGE_UNIT);

  if ((PRICE % CHANGE_UNIT) != 0 || (VAL1 % CHANGE_UNIT) != 0 ||
      (VAL2 % CHANGE_UNIT) != 0 || (VAL3 % CHANGE_UNIT) != 0) begin : g_unit_check
    $error("vend_change: PRICE and coin values must be multiples of CHANGE_UNIT");
  end

  if (MAX_CREDIT >= (1 << CREDIT_W)) begin : g_width_check
    $error("vend_change: CREDIT_W too narrow for maximum credit");
  end

  state_t              state_reg, state_next;
  logic [CREDIT_W-1:0] credit_reg, credit_next;
  logic [COUNT_W-1:0]  count_reg, count_next;
  logic                reject_reg, reject_next;
  logic [CREDIT_W-1:0] coin_val;
  logic [CREDIT_W-1:0] credit_sum;
  logic                coin_present;

  vend_coin_value #(
    .CREDIT_W (CREDIT_W),
    .VAL1     (VAL1),
    .VAL2     (VAL2),
    .VAL3     (VAL3)
  ) u_coin_value (
    .coin  (coin),
    .value (coin_val)
  );

  // Cannot overflow: in ACCUM credit is always below PRICE.
  assign credit_sum   = credit_reg + coin_val;
  assign coin_present = (coin != COIN_NONE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg  <= ACCUM;
      credit_reg <= '0;
      count_reg  <= '0;
      reject_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      credit_reg <= credit_next;
      count_reg  <= count_next;
      reject_reg <= reject_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    credit_next = credit_reg;
    count_next  = count_reg;
    reject_next = 1'b0;
    case (state_reg)
      ACCUM: begin
        if (cancel) begin
          // cancel wins over a simultaneous coin, which is handed back.
          reject_next = coin_present;
          if (credit_reg != '0) state_next = CHANGE;
        end else if (coin_present) begin
          credit_next = credit_sum;
          if (credit_sum >= PRICE_C) state_next = VEND;
        end
      end
      VEND: begin
        reject_next = coin_present;
        credit_next = credit_reg - PRICE_C;
        count_next  = count_reg + COUNT_W'(1);
        state_next  = (credit_reg == PRICE_C) ? ACCUM : CHANGE;
      end
      CHANGE: begin
        reject_next = coin_present;
        credit_next = credit_reg - UNIT_C;
        // This pulse pays the last unit; credit lands on zero at the same edge.
        if (credit_reg == UNIT_C) state_next = ACCUM;
      end
      default: begin
        state_next  = ACCUM;
        credit_next = '0;
      end
    endcase
  end

  assign newspaper   = (state_reg == VEND);
  assign change_out  = (state_reg == CHANGE);
  assign busy        = (state_reg != ACCUM);
  assign credit      = credit_reg;
  assign vend_count  = count_reg;
  assign coin_reject = reject_reg;

endmodule

// File: tb/tb_vend_change.sv
module tb_vend_change;

  localparam int PRICE       = 15;
  localparam int VAL1        = 5;
  localparam int VAL2        = 10;
  localparam int VAL3        = 25;
  localparam int CHANGE_UNIT = 5;
  localparam int CREDIT_W    = 7;
  localparam int COUNT_W     = 16;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic [1:0]          coin = 2'b00;
  logic                cancel = 1'b0;
  logic                newspaper, change_out, coin_reject, busy;
  logic [CREDIT_W-1:0] credit;
  logic [COUNT_W-1:0]  vend_count;

  vend_change #(
    .PRICE       (PRICE),
    .VAL1        (VAL1),
    .VAL2        (VAL2),
    .VAL3        (VAL3),
    .CHANGE_UNIT (CHANGE_UNIT),
    .CREDIT_W    (CREDIT_W),
    .COUNT_W     (COUNT_W)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .coin        (coin),
    .cancel      (cancel),
    .newspaper   (newspaper),
    .change_out  (change_out),
    .coin_reject (coin_reject),
    .busy        (busy),
    .credit      (credit),
    .vend_count  (vend_count)
  );

  always #5 clock = ~clock;

  // Reference model: money held, an item owed, coins of change still owed.
  int               m_credit = 0;
  bit               m_item_owed = 0;
  int               m_change_owed = 0;
  logic [COUNT_W-1:0] m_count = '0;
  bit               m_reject = 0;

  int n_cmp = 0;
  int n_fail = 0;
  int obs_news = 0;
  int obs_chg = 0;
  int obs_rej = 0;

  function automatic int coin_worth(input logic [1:0] c);
    case (c)
      2'b01:   return VAL1;
      2'b10:   return VAL2;
      2'b11:   return VAL3;
      default: return 0;
    endcase
  endfunction

  task automatic model_edge(input logic [1:0] c, input logic k, input logic r);
    bit was_busy;
    if (r) begin
      m_credit = 0; m_item_owed = 0; m_change_owed = 0; m_count = '0; m_reject = 0;
      return;
    end
    was_busy = m_item_owed || (m_change_owed > 0);
    m_reject = was_busy ? (c != 2'b00) : (k && c != 2'b00);
    if (m_item_owed) begin
      m_item_owed = 0;
      m_credit = m_credit - PRICE;
      m_count = m_count + 1'b1;
      m_change_owed = m_credit / CHANGE_UNIT;
    end else if (m_change_owed > 0) begin
      m_credit = m_credit - CHANGE_UNIT;
      m_change_owed = m_change_owed - 1;
    end else if (k) begin
      m_change_owed = m_credit / CHANGE_UNIT;
    end else if (c != 2'b00) begin
      m_credit = m_credit + coin_worth(c);
      if (m_credit >= PRICE) m_item_owed = 1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: drive at the falling edge, advance the model at the rising
  // edge, compare every output 1 time unit later.
  task automatic step(input logic [1:0] c, input logic k, input logic r);
    @(negedge clock);
    coin = c; cancel = k; reset = r;
    @(posedge clock);
    model_edge(c, k, r);
    #1;
    check("newspaper", {31'b0, newspaper}, {31'b0, m_item_owed});
    check("change_out", {31'b0, change_out}, {31'b0, (!m_item_owed && m_change_owed > 0)});
    check("busy", {31'b0, busy}, {31'b0, (m_item_owed || m_change_owed > 0)});
    check("credit", {25'b0, credit}, m_credit);
    check("vend_count", {16'b0, vend_count}, {16'b0, m_count});
    check("coin_reject", {31'b0, coin_reject}, {31'b0, m_reject});
    obs_news += int'(newspaper);
    obs_chg  += int'(change_out);
    obs_rej  += int'(coin_reject);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(2'b00, 1'b0, 1'b0);
  endtask

  task automatic clear_tallies();
    obs_news = 0; obs_chg = 0; obs_rej = 0;
  endtask

  initial begin
    // Reset state
    step(2'b00, 1'b0, 1'b1);
    step(2'b00, 1'b0, 1'b1);
    check("reset_credit", {25'b0, credit}, 0);

    // 1: three 5-unit coins, not back to back
    clear_tallies();
    step(2'b01, 0, 0); idle(1);
    step(2'b01, 0, 0); idle(1);
    step(2'b01, 0, 0); idle(3);
    check("t1_news", obs_news, 1);
    check("t1_chg", obs_chg, 0);
    check("t1_count", {16'b0, vend_count}, 1);

    // 2: 10+10 -> one change coin
    clear_tallies();
    step(2'b10, 0, 0); step(2'b10, 0, 0); idle(4);
    check("t2_news", obs_news, 1);
    check("t2_chg", obs_chg, 1);

    // 3: single 25 -> two change coins
    clear_tallies();
    step(2'b11, 0, 0); idle(5);
    check("t3_news", obs_news, 1);
    check("t3_chg", obs_chg, 2);
    check("t3_count", {16'b0, vend_count}, 3);

    // 4: refund, then cancel with nothing credited
    clear_tallies();
    step(2'b01, 0, 0); step(2'b00, 1, 0); idle(3);
    check("t4_news", obs_news, 0);
    check("t4_chg", obs_chg, 1);
    clear_tallies();
    step(2'b00, 1, 0); idle(2);
    check("t4b_chg", obs_chg, 0);
    check("t4b_busy", obs_news + obs_chg + obs_rej, 0);

    // 5: coins offered while busy, then coin+cancel with credit 5
    clear_tallies();
    step(2'b11, 0, 0);
    step(2'b10, 0, 0);  // during VEND
    step(2'b01, 0, 0);  // during first change pulse
    idle(3);
    check("t5_credit", {25'b0, credit}, 0);
    step(2'b01, 0, 0);
    step(2'b01, 1, 0);
    idle(3);
    check("t5_rej", obs_rej, 3);
    check("t5_chg", obs_chg, 3);

    // 6: reset during the first change pulse abandons the change
    clear_tallies();
    step(2'b11, 0, 0); idle(1);
    step(2'b00, 0, 1);
    check("t6_count", {16'b0, vend_count}, 0);
    step(2'b10, 0, 0); step(2'b01, 0, 0); idle(2);
    check("t6_news", obs_news, 2);
    check("t6_count2", {16'b0, vend_count}, 1);

    // Randomised traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [1:0] c;
      logic k, r;
      c = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
      k = ($urandom_range(0, 9) == 0);
      r = ($urandom_range(0, 199) == 0);
      step(c, k, r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
